// File: rtl/alu_ctrl_pkg.sv
// Shared types and opcode constants for the shift/logic issue controller.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_SLL = 4'h1;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SRA = 4'hD;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;

  // Requester id field is sized for the largest supported NREQ (8).
  localparam int SRC_W = 3;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ex_req_t;

  typedef struct packed {
    logic [4:0]       rd;
    logic [31:0]      data;
    logic [SRC_W-1:0] src;
  } wb_entry_t;

endpackage

// File: rtl/logic_shift_issue_ctrl_chk.sv
// Protocol checks for the issue controller.
module logic_shift_issue_ctrl_chk #(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst,
  input logic            ex_valid_out_i,
  input logic            inflight_i,
  input logic [NREQ-1:0] req_ready_i
);

  // A unit result must correspond to an issue from the previous cycle.
  a_result_has_issue: assert property (@(posedge clk) disable iff (rst)
    ex_valid_out_i |-> inflight_i);

  // At most one requester is accepted per cycle.
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready_i));

endmodule

// File: rtl/logic_shift_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the rotating pointer wins;
// the pointer moves just past the winner when the grant is taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx;
  logic          found;

  // Scan requesters in priority order starting at the pointer.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Next pointer is winner+1 wrapping at N.
  always_comb begin
    if (win_idx == PW'(N - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_idx + PW'(1);
    end
  end

  // Pointer only moves on a taken grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end else begin
      ptr_q <= ptr_q;
    end
  end

endmodule

// File: rtl/logic_shift_issue_ctrl.sv
// Issue controller sharing one single-cycle shift/logic unit among NREQ
// requesters, with destination-register hazard tracking and a small
// result buffer feeding a valid/ready writeback port.
module logic_shift_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int RBUF_DEPTH = 2,
  localparam int SW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ-1:0][3:0]   req_op_i,
  input  logic [NREQ-1:0][4:0]   req_rd_i,
  input  logic [NREQ-1:0][31:0]  req_rs1_i,
  input  logic [NREQ-1:0][31:0]  req_rs2_i,
  output logic                   ex_valid_o,
  output logic [3:0]             ex_op_o,
  output logic [4:0]             ex_rd_tag_o,
  output logic [31:0]            ex_rs1_o,
  output logic [31:0]            ex_rs2_o,
  input  logic                   ex_valid_out_i,
  input  logic [4:0]             ex_rd_tag_out_i,
  input  logic [31:0]            ex_result_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic [31:0]            wb_data_o,
  output logic [SW-1:0]          wb_src_o,
  output logic [31:0]            busy_o,
  output logic                   idle_o
);

  localparam int AW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
  localparam int CW = $clog2(RBUF_DEPTH + 1);

  logic [31:0]     busy_q, busy_d, set_mask_s, clr_mask_s;
  logic            inflight_q;
  logic [SW-1:0]   src_q, win_id_s;
  logic [CW-1:0]   occ_q;
  logic [AW-1:0]   rptr_q, wptr_q;
  wb_entry_t       mem_q [RBUF_DEPTH];
  wb_entry_t       head_s;
  ex_req_t         ex_req_s;
  logic [NREQ-1:0] elig_s, grant_s;
  logic            credit_s, pop_s, push_s, ex_valid_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    ptr_inc = (p == AW'(RBUF_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign head_s = mem_q[rptr_q];
  assign pop_s  = (occ_q != '0) && wb_ready_i;
  assign push_s = ex_valid_out_i;

  // Credit: outstanding results after this cycle's pop must leave room.
  assign credit_s = ({1'b0, occ_q} + {{CW{1'b0}}, inflight_q}) <
                    ((CW+1)'(RBUF_DEPTH) + {{CW{1'b0}}, pop_s});

  // A requester is eligible when its destination is free and credit exists.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i] = req_valid_i[i] && credit_s &&
                  ((req_rd_i[i] == 5'd0) || !busy_q[req_rd_i[i]]);
    end
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig_s),
    .advance (ex_valid_s),
    .grant   (grant_s)
  );

  // One-hot AND-OR mux of the winner's fields; all zero without a grant.
  always_comb begin
    ex_req_s = '0;
    win_id_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      ex_req_s.op  = ex_req_s.op  | (req_op_i[i]  & {4{grant_s[i]}});
      ex_req_s.rd  = ex_req_s.rd  | (req_rd_i[i]  & {5{grant_s[i]}});
      ex_req_s.rs1 = ex_req_s.rs1 | (req_rs1_i[i] & {32{grant_s[i]}});
      ex_req_s.rs2 = ex_req_s.rs2 | (req_rs2_i[i] & {32{grant_s[i]}});
      win_id_s     = win_id_s     | (SW'(i) & {SW{grant_s[i]}});
    end
  end

  assign ex_valid_s  = |grant_s;
  assign req_ready_o = grant_s;
  assign ex_valid_o  = ex_valid_s;
  assign ex_op_o     = ex_req_s.op;
  assign ex_rd_tag_o = ex_req_s.rd;
  assign ex_rs1_o    = ex_req_s.rs1;
  assign ex_rs2_o    = ex_req_s.rs2;

  // Busy scoreboard update; a set in the same cycle as a clear wins.
  always_comb begin
    if (ex_valid_s && (ex_req_s.rd != 5'd0)) begin
      set_mask_s = 32'd1 << ex_req_s.rd;
    end else begin
      set_mask_s = 32'd0;
    end
    if (pop_s) begin
      clr_mask_s = 32'd1 << head_s.rd;
    end else begin
      clr_mask_s = 32'd0;
    end
    busy_d = ((busy_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // Issue-side state: in-flight flag, issuing requester, busy bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      src_q      <= '0;
      busy_q     <= 32'd0;
    end else begin
      inflight_q <= ex_valid_s;
      src_q      <= win_id_s;
      busy_q     <= busy_d;
    end
  end

  // Result buffer: circular storage with read/write pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= '{rd: ex_rd_tag_out_i, data: ex_result_i, src: SRC_W'(src_q)};
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_s) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign wb_valid_o = (occ_q != '0);
  assign wb_rd_o    = head_s.rd;
  assign wb_data_o  = head_s.data;
  assign wb_src_o   = head_s.src[SW-1:0];
  assign busy_o     = busy_q;
  assign idle_o     = !inflight_q && (occ_q == '0) && (busy_q == 32'd0);

  logic_shift_issue_ctrl_chk #(.NREQ(NREQ)) u_chk (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_out_i (ex_valid_out_i),
    .inflight_i     (inflight_q),
    .req_ready_i    (req_ready_o)
  );

endmodule

// File: tb/tb_logic_shift_issue_ctrl.sv
// Scoreboard bench for logic_shift_issue_ctrl with a behavioural execution
// unit and a transaction-level reference model.
module tb_logic_shift_issue_ctrl;
  import alu_ctrl_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 2;

  logic clk, rst;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ-1:0][3:0]  req_op;
  logic [NREQ-1:0][4:0]  req_rd;
  logic [NREQ-1:0][31:0] req_rs1, req_rs2;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rd_tag;
  logic [31:0] ex_rs1, ex_rs2;
  logic        u_v;
  logic [4:0]  u_tag;
  logic [31:0] u_res;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_src;
  logic [31:0] busy;
  logic        idle;

  // next-cycle stimulus, applied at the falling edge by step()
  logic [NREQ-1:0]       nv;
  logic [NREQ-1:0][3:0]  nop;
  logic [NREQ-1:0][4:0]  nrd;
  logic [NREQ-1:0][31:0] nrs1, nrs2;
  logic                  nwbr;

  typedef struct { logic [4:0] rd; logic [31:0] data; int src; int cyc; } ent_t;
  ent_t mq[$];   // model: issued, not yet written back
  ent_t sq[$];   // scoreboard consumed by the monitor
  int   mptr, cyc, total, bad;

  logic_shift_issue_ctrl #(.NREQ(NREQ), .RBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .ex_valid_o(ex_valid), .ex_op_o(ex_op), .ex_rd_tag_o(ex_rd_tag),
    .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
    .ex_valid_out_i(u_v), .ex_rd_tag_out_i(u_tag), .ex_result_i(u_res),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .wb_src_o(wb_src), .busy_o(busy), .idle_o(idle)
  );

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural single-cycle execution unit with registered output
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_v <= 1'b0; u_tag <= 5'd0; u_res <= 32'd0;
    end else begin
      u_v   <= ex_valid;
      u_tag <= ex_rd_tag;
      u_res <= ex_valid ? ref_alu(ex_op, ex_rs1, ex_rs2) : 32'd0;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every writeback handshake
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && wb_valid && wb_ready) begin
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected actual=rd%0d/%0h required=none", wb_rd, wb_data);
        end else begin
          e = sq.pop_front();
          chk("wb_rd", 64'(wb_rd), 64'(e.rd));
          chk("wb_data", 64'(wb_data), 64'(e.data));
          chk("wb_src", 64'(wb_src), 64'(e.src));
        end
      end
    end
  end

  // one cycle: apply stimulus, predict arbitration from model state, check, advance model
  task automatic step();
    int win, outst, i;
    bit wbv, pop, credit;
    logic [31:0] mbusy;
    ent_t e;
    @(negedge clk);
    req_valid = nv; req_op = nop; req_rd = nrd; req_rs1 = nrs1; req_rs2 = nrs2;
    wb_ready = nwbr;
    #1;
    outst  = mq.size();
    wbv    = (outst > 0) && (mq[0].cyc <= cyc - 2);
    pop    = wbv && wb_ready;
    credit = (outst - (pop ? 1 : 0)) < DEPTH;
    mbusy  = 32'd0;
    foreach (mq[k]) if (mq[k].rd != 5'd0) mbusy[mq[k].rd] = 1'b1;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (mptr + k) % NREQ;
      if (win < 0 && req_valid[i] && credit && (req_rd[i] == 5'd0 || !mbusy[req_rd[i]]))
        win = i;
    end
    chk("req_ready", 64'(req_ready), (win >= 0) ? (64'd1 << win) : 64'd0);
    chk("ex_valid", 64'(ex_valid), (win >= 0) ? 64'd1 : 64'd0);
    chk("ex_op", 64'(ex_op), (win >= 0) ? 64'(req_op[win]) : 64'd0);
    chk("ex_rd_tag", 64'(ex_rd_tag), (win >= 0) ? 64'(req_rd[win]) : 64'd0);
    chk("ex_rs1", 64'(ex_rs1), (win >= 0) ? 64'(req_rs1[win]) : 64'd0);
    chk("ex_rs2", 64'(ex_rs2), (win >= 0) ? 64'(req_rs2[win]) : 64'd0);
    chk("wb_valid", 64'(wb_valid), 64'(wbv));
    chk("busy", 64'(busy), 64'(mbusy));
    chk("idle", 64'(idle), (outst == 0) ? 64'd1 : 64'd0);
    if (pop) void'(mq.pop_front());
    if (win >= 0) begin
      e.rd = req_rd[win];
      e.data = ref_alu(req_op[win], req_rs1[win], req_rs2[win]);
      e.src = win; e.cyc = cyc;
      mq.push_back(e); sq.push_back(e);
      mptr = (win + 1) % NREQ;
    end
    cyc++;
  endtask

  task automatic reset_chk();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_op", 64'(ex_op), 64'd0);
    chk("rst_ex_rd", 64'(ex_rd_tag), 64'd0);
    chk("rst_ex_rs1", 64'(ex_rs1), 64'd0);
    chk("rst_ex_rs2", 64'(ex_rs2), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_src", 64'(wb_src), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
  endtask

  task automatic idle_steps(int n);
    nv = '0; nwbr = 1'b1;
    repeat (n) step();
  endtask

  task automatic set_req(int i, logic [3:0] op, logic [4:0] rd, logic [31:0] a, logic [31:0] b);
    nop[i] = op; nrd[i] = rd; nrs1[i] = a; nrs2[i] = b;
  endtask

  initial begin
    logic [3:0] ops [8];
    ops = '{OP_SLL, OP_SRL, OP_SRA, OP_XOR, OP_OR, OP_AND, 4'h0, 4'hF};
    total = 0; bad = 0; mptr = 0; cyc = 0;
    rst = 1'b1; wb_ready = 1'b0;
    req_valid = '0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    nv = '0; nop = '0; nrd = '0; nrs1 = '0; nrs2 = '0; nwbr = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset_chk();
    @(negedge clk);
    rst = 1'b0;

    // single issue: SLL 1<<4 into r5
    set_req(0, OP_SLL, 5'd5, 32'h1, 32'd4);
    nv = 4'b0001; step();
    nv = '0; step();
    chk("sll_busy_t1", 64'(busy[5]), 64'd1);
    step();
    chk("sll_wb_data", 64'(wb_data), 64'h10);
    chk("sll_wb_rd", 64'(wb_rd), 64'd5);
    chk("sll_busy_t2", 64'(busy[5]), 64'd1);
    step();
    chk("sll_busy_clear", 64'(busy[5]), 64'd0);
    idle_steps(2);

    // round robin with distinct destinations
    for (int i = 0; i < NREQ; i++) set_req(i, OP_XOR, 5'(i + 1), 32'(i * 3), 32'h55);
    nv = 4'b1111; nwbr = 1'b1;
    repeat (9) step();
    idle_steps(4);

    // destination collision on r7, plus an rd=0 requester that never blocks
    set_req(0, OP_SRA, 5'd7, 32'h8000_0000, 32'd31);
    set_req(1, OP_OR, 5'd7, 32'h1234_0000, 32'h0000_5678);
    set_req(2, OP_AND, 5'd0, 32'hFFFF_0000, 32'h0F0F_0F0F);
    nv = 4'b0001; step();
    nv = 4'b0010; step();
    step();
    chk("sra_wb_data", 64'(wb_data), 64'hFFFF_FFFF);
    chk("collision_hold", 64'(req_ready[1]), 64'd0);
    step();
    chk("collision_release", 64'(req_ready[1]), 64'd1);
    nv = 4'b0100; repeat (3) step();
    idle_steps(4);

    // backpressure: credit limit, then a single release
    for (int i = 0; i < NREQ; i++) set_req(i, OP_SRL, 5'(i + 8), 32'hF000_0000 + 32'(i), 32'(i));
    nv = 4'b1111; nwbr = 1'b0;
    repeat (5) step();
    nwbr = 1'b1; step();
    chk("bp_release_accept", 64'($countones(req_ready)), 64'd1);
    nwbr = 1'b0; repeat (3) step();
    nv = '0; nwbr = 1'b1; repeat (5) step();

    // logic ops back to back
    set_req(3, OP_XOR, 5'd12, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    nv = 4'b1000; step();
    set_req(3, OP_OR, 5'd13, 32'hF0F0_F0F0, 32'h0FF0_0FF0); step();
    set_req(3, OP_AND, 5'd14, 32'hF0F0_F0F0, 32'h0FF0_0FF0); step();
    chk("xor_wb_data", 64'(wb_data), 64'hFF00_FF00);
    nv = '0; step();
    chk("or_wb_data", 64'(wb_data), 64'hFFF0_FFF0);
    step();
    chk("and_wb_data", 64'(wb_data), 64'h00F0_00F0);
    idle_steps(3);

    // reset with one result buffered and one in flight
    set_req(0, OP_SLL, 5'd3, 32'h3, 32'd1);
    set_req(1, OP_SLL, 5'd4, 32'h5, 32'd2);
    nv = 4'b0011; nwbr = 1'b0; repeat (2) step();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; wb_ready = 1'b0;
    #1 reset_chk();
    mq.delete(); sq.delete(); mptr = 0;
    @(negedge clk);
    rst = 1'b0;
    nv = '0; nwbr = 1'b1;
    repeat (4) step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      nv = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++)
        set_req(i, ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), $urandom, $urandom);
      nwbr = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_steps(6);
    chk("scoreboard_empty", 64'(sq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_shift_issue_ctrl.md
# logic_shift_issue_ctrl

Issue controller that shares the single-cycle shift/logic execution unit among NREQ requesters. It performs round-robin arbitration, holds back a request whose destination register still has a result in flight, and drives the unit's input bus. It also captures the unit's registered output into a small result buffer and presents results on a valid/ready writeback port. The block sits between the issue queues and the register-file writeback arbiter.

## Interface
- NREQ, 4, number of requesters (2..8)
- RBUF_DEPTH, 2, result buffer entries (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request present
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_op  in  NREQ×4  operation code per requester
- req_rd  in  NREQ×5  destination register per requester
- req_rs1, req_rs2  in  NREQ×32  operands per requester
- ex_valid  out  1  issue to unit
- ex_op  out  4  opcode to unit
- ex_rd_tag  out  5  destination register to unit
- ex_rs1, ex_rs2  out  32  operands to unit
- ex_valid_out  in  1  unit result valid
- ex_rd_tag_out  in  5  unit result tag
- ex_result  in  32  unit result
- wb_valid  out  1  buffered result available
- wb_ready  in  1  writeback accepts
- wb_rd  out  5  result destination
- wb_data  out  32  result value
- wb_src  out  $clog2(NREQ)  requester that issued it
- busy  out  32  per-register in-flight bits; bit 0 is always 0
- idle  out  1  nothing in flight, buffer empty, busy all zero

## Operation
- Eligible(i) = req_valid[i] && (req_rd[i]==0 || !busy[req_rd[i]]) && credit.
- credit = (occ + inflight − (wb_valid && wb_ready)) < RBUF_DEPTH.
  - occ: buffer entry count.
  - inflight: 1 if an issue occurred in the previous cycle.
- Round-robin arbitration over eligible requesters, starting at pointer ptr.
  - The winner gets req_ready high, and its fields are driven combinationally onto ex_*. ex_valid=1.
  - On a grant, ptr ← winner+1 mod NREQ. With no grant, ptr holds.
- With no grant: ex_valid=0 and ex_* = 0.
- On accept, busy[rd] is set if rd≠0. The winner id is registered into src_q alongside inflight.
- When ex_valid_out=1, {ex_rd_tag_out, ex_result, src_q} is pushed into the FIFO.
  - ex_valid_out without inflight is an assertion failure.
- FIFO head drives wb_*. wb_valid = (occ≠0).
- On wb_valid && wb_ready: pop, and clear busy[wb_rd].
  - If the same cycle also sets the same bit, set wins. This cannot happen via eligibility, but the implementation must still handle it.
- Opcodes are not checked. Illegal codes issue and return the unit's output (0).

## Timing
- Request accepted in cycle t.
  - Unit result is valid in cycle t+1.
  - wb_valid is high in cycle t+2 at the earliest.
- Throughput is 1/cycle while wb_ready=1 and destination registers do not collide.
- A destination register collision stalls the second request until the cycle after the first one's writeback handshake.
- wb_ready → credit → req_ready is a permitted combinational path. There is no other combinational input-to-output path except req_* → ex_*.
- Pushes and pops in the same cycle with a full buffer are legal, because credit guarantees no overflow.
- Reset values:
  - req_ready=0, ex_valid=0, ex_* = 0, wb_valid=0, wb_rd=0, wb_data=0, wb_src=0.
  - busy=0, idle=1, ptr=0, occ=0, inflight=0, FIFO pointers=0.
- Reset mid-operation discards in-flight and buffered results. The execution unit shares rst.

## Structure
- Package alu_ctrl_pkg:
  - Opcodes OP_SLL=4'h1, OP_SRL=4'h5, OP_SRA=4'hD, OP_XOR=4'h4, OP_OR=4'h6, OP_AND=4'h7.
  - Packed struct ex_req_t {op, rd, rs1, rs2}.
  - Packed struct wb_entry_t {rd, data, src}.
- Sub-module rr_arbiter: parameter N; inputs req[N], advance; output grant one-hot; rotating priority pointer inside.
- The FIFO stays inline: circular buffer, read/write pointers, occ counter.

## Test plan
- Single issue: req0 issues OP_SLL, rs1=0x0000_0001, rs2=4, rd=5.
  - ex_valid in the same cycle.
  - wb_valid at t+2 with wb_rd=5, wb_data=0x10, wb_src=0.
  - busy[5] is high t+1..t+2 and clears after the handshake.
- Round-robin: all 4 requesters hold valid with distinct rd and wb_ready=1.
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - wb_src follows the same order 2 cycles later.
- Collision: req0 issues OP_SRA, rd=7, rs1=0x8000_0000, rs2=31. req1 is already waiting with rd=7.
  - req1 is not granted until the cycle after wb handshake of 0xFFFF_FFFF.
  - rd=0 requests are never blocked.
- Backpressure: wb_ready=0 with continuous requests.
  - Exactly RBUF_DEPTH accepts, then req_ready=0.
  - Raising wb_ready for 1 cycle releases exactly 1 further accept in that same cycle.
  - No results are lost or reordered.
- Reset mid-flight: assert rst while 1 result is in flight and 1 is buffered.
  - All outputs go to their reset values.
  - After release, idle=1 and no wb_valid appears.
- Logic ops: OP_XOR/OR/AND with rs1=0xF0F0_F0F0, rs2=0x0FF0_0FF0.
  - Expected results 0xFF00_FF00, 0xFFF0_FFF0, 0x00F0_00F0 respectively.
